// File: rtl/key_click_decoder_pkg.sv
// Shared state encoding and elaboration helpers for key gesture decoders.
// Any future keypad or gesture block imports this package.
package key_click_decoder_pkg;

  localparam logic [2:0] KS_IDLE   = 3'd0;
  localparam logic [2:0] KS_PRESS1 = 3'd1;
  localparam logic [2:0] KS_WAIT2  = 3'd2;
  localparam logic [2:0] KS_PRESS2 = 3'd3;
  localparam logic [2:0] KS_LONG   = 3'd4;

  function automatic longint unsigned max3(input longint unsigned a,
                                           input longint unsigned b,
                                           input longint unsigned c);
    longint unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_click_decoder.sv
// Classifies debounced press/release edge pulses into single click, double click,
// long press and long-press auto-repeat gestures. One instance per key.
module key_click_decoder
  import key_click_decoder_pkg::*;
#(
  parameter int          CNT_W        = 24,
  parameter int unsigned LONG_CNT     = 12_500_000,
  parameter int unsigned GAP_CNT      = 10_000_000,
  parameter int unsigned REPEAT_CNT   = 5_000_000,
  parameter bit          PRESS_ON_POS = 1'b1
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic key_posedge,
  input  logic key_negedge,
  output logic click_single,
  output logic click_double,
  output logic long_start,
  output logic long_repeat,
  output logic key_held
);

  localparam longint unsigned MAX_CNT = max3(LONG_CNT, GAP_CNT, REPEAT_CNT);

  if (CNT_W < 1 || CNT_W > 62 || MAX_CNT >= (64'd1 << CNT_W)) begin : g_cnt_w_chk
    $error("key_click_decoder: CNT_W too narrow for the largest count");
  end
  if (LONG_CNT < 2 || GAP_CNT < 2 || REPEAT_CNT < 2) begin : g_cnt_min_chk
    $error("key_click_decoder: LONG_CNT, GAP_CNT and REPEAT_CNT must be >= 2");
  end

  localparam logic [CNT_W-1:0] LONG_M   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_M    = CNT_W'(GAP_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_M = CNT_W'(REPEAT_CNT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cs_q, cs_d, cd_q, cd_d, ls_q, ls_d, lr_q, lr_d, held_q, held_d;
  logic             press, release_e, one_edge;

  // Simultaneous edges cancel out; otherwise map edges to press/release by polarity.
  assign one_edge  = key_posedge ^ key_negedge;
  assign press     = one_edge & (PRESS_ON_POS ? key_posedge : key_negedge);
  assign release_e = one_edge & (PRESS_ON_POS ? key_negedge : key_posedge);

  always_comb begin
    state_d = state_q;
    cs_d    = 1'b0;
    cd_d    = 1'b0;
    ls_d    = 1'b0;
    lr_d    = 1'b0;
    case (state_q)
      KS_IDLE: if (press) state_d = KS_PRESS1;
      KS_PRESS1: begin
        if (release_e) state_d = KS_WAIT2;
        else if (cnt_q == LONG_M) begin
          state_d = KS_LONG;
          ls_d    = 1'b1;
        end
      end
      KS_WAIT2: begin
        if (press) state_d = KS_PRESS2;
        else if (cnt_q == GAP_M) begin
          state_d = KS_IDLE;
          cs_d    = 1'b1;
        end
      end
      KS_PRESS2: begin
        if (release_e) begin
          state_d = KS_IDLE;
          cd_d    = 1'b1;
        end else if (cnt_q == LONG_M) begin
          state_d = KS_LONG;
          cs_d    = 1'b1;
          ls_d    = 1'b1;
        end
      end
      KS_LONG: begin
        if (release_e) state_d = KS_IDLE;
        else if (cnt_q == REPEAT_M) lr_d = 1'b1;
      end
      default: state_d = KS_IDLE;
    endcase
  end

  // The counter restarts on any state change and on each repeat, so it never wraps.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_q == KS_IDLE || state_d != state_q || lr_d) cnt_d = '0;
  end

  assign held_d = (state_d == KS_PRESS1) || (state_d == KS_PRESS2) || (state_d == KS_LONG);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= KS_IDLE;
      cnt_q   <= '0;
      cs_q    <= 1'b0;
      cd_q    <= 1'b0;
      ls_q    <= 1'b0;
      lr_q    <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= cs_d;
      cd_q    <= cd_d;
      ls_q    <= ls_d;
      lr_q    <= lr_d;
      held_q  <= held_d;
    end
  end

  assign click_single = cs_q;
  assign click_double = cd_q;
  assign long_start   = ls_q;
  assign long_repeat  = lr_q;
  assign key_held     = held_q;

endmodule

// File: tb/tb_key_click_decoder.sv
// Self-checking bench for key_click_decoder: vector table, scripted corner sequences,
// and random edges compared every cycle against a timestamp-based gesture model.
module tb_key_click_decoder;

  localparam int LONG = 8, GAP = 6, REP = 4;

  logic clkin = 1'b0, rst_n = 1'b0;
  logic key_posedge = 1'b0, key_negedge = 1'b0;
  logic click_single, click_double, long_start, long_repeat, key_held;

  key_click_decoder #(
    .CNT_W(24), .LONG_CNT(LONG), .GAP_CNT(GAP), .REPEAT_CNT(REP), .PRESS_ON_POS(1'b1)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .key_posedge(key_posedge), .key_negedge(key_negedge),
    .click_single(click_single), .click_double(click_double), .long_start(long_start),
    .long_repeat(long_repeat), .key_held(key_held)
  );

  always #5 clkin = ~clkin;

  int n_chk = 0, n_fail = 0;
  logic [4:0] outs;
  assign outs = {key_held, click_single, click_double, long_start, long_repeat};

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got held/cs/cd/ls/lr=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Gesture model: phase plus the cycle at which the phase was entered; timing by subtraction.
  int unsigned cyc = 0, t_ent = 0;
  int phase = 0;  // 0 idle, 1 first press, 2 gap, 3 second press, 4 long hold
  logic [4:0] exp_o = '0;
  bit chk_en = 0;

  always @(posedge clkin or negedge rst_n) begin
    int unsigned now, el;
    bit pr, rl;
    if (!rst_n) begin
      phase = 0;
      exp_o = '0;
      if (clkin) cyc++;
    end else begin
      now = cyc;
      cyc++;
      el  = now - t_ent;
      pr  = key_posedge && !key_negedge;
      rl  = key_negedge && !key_posedge;
      exp_o[3:0] = '0;
      case (phase)
        0: if (pr) begin phase = 1; t_ent = now + 1; end
        1: if (rl) begin phase = 2; t_ent = now + 1; end
           else if (el == LONG - 1) begin phase = 4; t_ent = now + 1; exp_o[1] = 1; end
        2: if (pr) begin phase = 3; t_ent = now + 1; end
           else if (el == GAP - 1) begin phase = 0; exp_o[3] = 1; end
        3: if (rl) begin phase = 0; exp_o[2] = 1; end
           else if (el == LONG - 1) begin phase = 4; t_ent = now + 1; exp_o[3] = 1; exp_o[1] = 1; end
        default: if (rl) phase = 0;
                 else if (el % REP == REP - 1) exp_o[0] = 1;
      endcase
      exp_o[4] = (phase == 1 || phase == 3 || phase == 4);
    end
  end

  always @(negedge clkin) if (chk_en) chk("model", outs, exp_o);

  typedef struct {
    logic       pos;
    logic       neg;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic p, input logic n, input logic [4:0] e);
    vec_t v;
    v.pos = p; v.neg = n; v.exp = e;
    vecs.push_back(v);
  endtask

  // Scripted sequences: id 0 long hold with repeats, id 1 click->long overlap, id 2 into LONG.
  function automatic logic [1:0] stim(input int id, input int off);
    case (id)
      0: return {off == 0, off == 20};
      1: return {off == 0 || off == 4, off == 2 || off == 18};
      default: return {off == 0, 1'b0};
    endcase
  endfunction

  function automatic logic [4:0] hexp(input int id, input int o);
    logic [4:0] e;
    e = '0;
    case (id)
      0: begin
        e[4] = (o >= 1 && o <= 20);
        e[1] = (o == 9);
        e[0] = (o == 13 || o == 17);
      end
      1: begin
        e[4] = (o >= 1 && o <= 2) || (o >= 5 && o <= 18);
        e[3] = (o == 13);
        e[1] = (o == 13);
        e[0] = (o == 17);
      end
      default: begin
        e[4] = (o >= 1);
        e[1] = (o == 9);
      end
    endcase
    return e;
  endfunction

  task automatic run_hand(input int id, input int n, input string nm);
    for (int off = 0; off < n; off++) begin
      {key_posedge, key_negedge} = stim(id, off);
      @(posedge clkin); #1;
      chk(nm, outs, hexp(id, off + 1));
    end
    key_posedge = 0; key_negedge = 0;
  endtask

  initial begin
    // single click
    add(1, 0, 5'b10000); add(0, 0, 5'b10000); add(0, 0, 5'b10000); add(0, 1, 5'b00000);
    for (int i = 0; i < 5; i++) add(0, 0, 5'b00000);
    add(0, 0, 5'b01000); add(0, 0, 5'b00000);
    // both edges together in idle
    add(1, 1, 5'b00000);
    for (int i = 0; i < 3; i++) add(0, 0, 5'b00000);
    // double click, then no late single
    add(1, 0, 5'b10000); add(0, 0, 5'b10000); add(0, 0, 5'b10000); add(0, 1, 5'b00000);
    add(0, 0, 5'b00000); add(1, 0, 5'b10000); add(0, 0, 5'b10000); add(0, 1, 5'b00100);
    for (int i = 0; i < 8; i++) add(0, 0, 5'b00000);

    repeat (3) @(posedge clkin);
    #1 chk("reset_state", outs, 5'b00000);
    rst_n = 1;
    chk_en = 1;

    for (int k = 0; k < vecs.size(); k++) begin
      key_posedge = vecs[k].pos; key_negedge = vecs[k].neg;
      @(posedge clkin); #1;
      chk($sformatf("vec%0d", k), outs, vecs[k].exp);
    end
    key_posedge = 0; key_negedge = 0;

    run_hand(0, 24, "long_hold");
    repeat (2) @(posedge clkin); #1;
    run_hand(1, 20, "click_then_long");
    repeat (2) @(posedge clkin); #1;
    run_hand(2, 11, "reach_long");

    // Reset while held in LONG: outputs drop at once, a later release does nothing.
    #1 rst_n = 0;
    #1 chk("rst_async", outs, 5'b00000);
    @(posedge clkin); #1 rst_n = 1;
    key_negedge = 1;
    @(posedge clkin); #1 key_negedge = 0;
    chk("rst_release_ignored", outs, 5'b00000);
    for (int i = 0; i < GAP + 2; i++) begin
      @(posedge clkin); #1;
      chk("rst_quiet", outs, 5'b00000);
    end

    for (int blk = 0; blk < 15; blk++) begin
      int dens;
      dens = $urandom_range(6, 40);
      for (int i = 0; i < 200; i++) begin
        int r;
        r = $urandom_range(0, dens);
        key_posedge = (r <= 1) || (r == 4);
        key_negedge = (r == 2) || (r == 3) || (r == 4);
        @(posedge clkin); #1;
      end
    end
    key_posedge = 0; key_negedge = 0;
    repeat (3) @(posedge clkin);
    @(negedge clkin); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
